universal_sr: RTL and testbench

UNIVERSAL_SR -- requirements
Module: universal_sr

---
 rtl/universal_sr_pkg.sv | 13 +
 rtl/sr_burst_ctrl.sv | 77 +++++++
 rtl/universal_sr.sv | 82 ++++++++
 tb/tb_universal_sr.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/universal_sr_pkg.sv
// Shared constants and types for the universal shift register.
// Holds shift direction encodings and the burst FSM state type.
package universal_sr_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/sr_burst_ctrl.sv
// Burst controller: IDLE/BURST FSM with step counter.
// Decides when the datapath shifts and flags burst completion.
module sr_burst_ctrl
  import universal_sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic aclr,
  input  logic aset,
  input  logic enable,
  input  logic sclr,
  input  logic sset,
  input  logic load,
  input  logic start,
  input  logic shift,
  output logic step_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic            abort;

  assign abort  = sclr | sset | load;
  assign step_o = enable & ~abort &
                  ((state_q == BURST) | start | shift);
  assign busy_o = (state_q == BURST);
  assign done_o = done_q;

  // Next-state, counter and completion pulse.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (enable) begin
      if (abort) begin
        state_d = IDLE;
        count_d = '0;
      end else if (state_q == IDLE) begin
        if (start) begin
          if (WIDTH == 1) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
            count_d = CW'(1);
          end
        end
      end else if (count_q == LAST) begin
        state_d = IDLE;
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Control registers; either async input forces idle.
  always_ff @(posedge clock or posedge aclr or posedge aset) begin
    if (aclr || aset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/universal_sr.sv
// Universal shift register with load, rotate and burst shifting.
// Datapath lives here; sequencing lives in sr_burst_ctrl.
module universal_sr
  import universal_sr_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = '1
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             aset,
  input  logic             sclr,
  input  logic             sset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             shift,
  input  logic             start,
  input  logic             dir,
  input  logic             rotate,
  input  logic             shiftin,
  output logic [WIDTH-1:0] q,
  output logic             shiftout,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d, shifted;
  logic             in_bit, step, aset_eff;

  // Gating aset by aclr makes aclr release re-trigger the preset.
  assign aset_eff = aset & ~aclr;

  sr_burst_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clock  (clock),
    .aclr   (aclr),
    .aset   (aset),
    .enable (enable),
    .sclr   (sclr),
    .sset   (sset),
    .load   (load),
    .start  (start),
    .shift  (shift),
    .step_o (step),
    .busy_o (busy),
    .done_o (done)
  );

  assign shiftout = (dir == DIR_RIGHT) ? q_q[0] : q_q[WIDTH-1];
  assign in_bit   = rotate ? shiftout : shiftin;

  generate
    if (WIDTH == 1) begin : g_one
      assign shifted = in_bit;
    end else begin : g_many
      assign shifted = (dir == DIR_RIGHT) ?
                       {in_bit, q_q[WIDTH-1:1]} :
                       {q_q[WIDTH-2:0], in_bit};
    end
  endgenerate

  // Synchronous operation priority: sclr, sset, load, shift step.
  always_comb begin
    q_d = q_q;
    if (enable) begin
      if (sclr)      q_d = '0;
      else if (sset) q_d = SET_VALUE;
      else if (load) q_d = data;
      else if (step) q_d = shifted;
    end
  end

  // Register with async clear dominating async preset.
  always_ff @(posedge clock or posedge aclr or posedge aset_eff) begin
    if (aclr)          q_q <= '0;
    else if (aset_eff) q_q <= SET_VALUE;
    else               q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: tb/tb_universal_sr.sv
// Self-checking bench for universal_sr (WIDTH=8).
// Directed scenarios plus random stimulus against a reference model.
module tb_universal_sr;

  logic       clock = 1'b0;
  logic       aclr, aset, sclr, sset, enable, load;
  logic [7:0] data;
  logic       shift, start, dir, rotate, shiftin;
  logic [7:0] q;
  logic       shiftout, busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: register value, steps left in burst, done flag.
  int mq, rem;
  bit mdone;

  always #5 clock = ~clock;

  universal_sr #(.WIDTH(8), .SET_VALUE(8'hFF)) dut (
    .clock(clock), .aclr(aclr), .aset(aset), .sclr(sclr),
    .sset(sset), .enable(enable), .load(load), .data(data),
    .shift(shift), .start(start), .dir(dir), .rotate(rotate),
    .shiftin(shiftin), .q(q), .shiftout(shiftout),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mout();
    return dir ? (mq & 1) : ((mq >> 7) & 1);
  endfunction

  function automatic int mshift();
    int b;
    b = rotate ? mout() : int'(shiftin);
    if (dir) return (mq >> 1) | (b << 7);
    return ((mq << 1) & 255) | b;
  endfunction

  task automatic model_edge();
    mdone = 0;
    if (!enable) return;
    if (sclr)      begin mq = 0;    rem = 0; end
    else if (sset) begin mq = 255;  rem = 0; end
    else if (load) begin mq = data; rem = 0; end
    else if (rem == 0) begin
      if (start) begin mq = mshift(); rem = 7; end
      else if (shift) mq = mshift();
    end else begin
      mq = mshift();
      rem--;
      mdone = (rem == 0);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".q"}, q, mq);
    chk({tag, ".busy"}, busy, rem != 0);
    chk({tag, ".done"}, done, mdone);
    chk({tag, ".so"}, shiftout, mout());
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    compare(tag);
  endtask

  task automatic quiet();
    sclr = 0; sset = 0; load = 0; shift = 0; start = 0;
    enable = 1;
  endtask

  int nb, nd;

  initial begin
    aclr = 1; aset = 0; quiet();
    data = 0; dir = 0; rotate = 0; shiftin = 0;
    mq = 0; rem = 0; mdone = 0;
    #2;
    compare("reset");
    @(negedge clock);
    aclr = 0;
    @(posedge clock); #1;

    // Left shift with serial input.
    load = 1; data = 8'hA5; cyc("ldA5"); quiet();
    dir = 0; rotate = 0; shiftin = 1; #1;
    chk("so_pre", shiftout, 1);
    shift = 1; cyc("shl");
    chk("shl_q", q, 8'h4B);
    chk("so_post", shiftout, 0);
    quiet();

    // Right rotate.
    load = 1; data = 8'h81; cyc("ld81"); quiet();
    dir = 1; rotate = 1; shift = 1; cyc("rotr");
    chk("rotr_q", q, 8'hC0);
    quiet();

    // Full burst.
    load = 1; data = 8'h3C; cyc("ld3C"); quiet();
    dir = 1; rotate = 0; shiftin = 0; start = 1;
    cyc("bst_s"); start = 0;
    nb = int'(busy); nd = 0;
    for (int i = 0; i < 10; i++) begin
      cyc("bst"); nb += int'(busy); nd += int'(done);
    end
    chk("bst_q", q, 8'h00);
    chk("bst_busy", nb, 7);
    chk("bst_done", nd, 1);

    // Burst with enable stalled for two cycles.
    load = 1; data = 8'h3C; cyc("ld3Cb"); quiet();
    start = 1; cyc("stl_s"); start = 0;
    nb = int'(busy); nd = 0;
    for (int i = 0; i < 12; i++) begin
      enable = !(i == 3 || i == 4);
      cyc("stl"); nb += int'(busy); nd += int'(done);
    end
    enable = 1;
    chk("stl_q", q, 8'h00);
    chk("stl_busy", nb, 9);
    chk("stl_done", nd, 1);

    // Abort via sclr after step 3; start during burst ignored.
    load = 1; data = 8'hF0; cyc("ldF0"); quiet();
    dir = 0; shiftin = 1; start = 1; cyc("ab_s1");
    cyc("ab_s2"); cyc("ab_s3"); start = 0;
    chk("ab_busy3", busy, 1);
    sclr = 1; cyc("ab_clr"); sclr = 0;
    chk("ab_q", q, 8'h00);
    chk("ab_busy", busy, 0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      cyc("ab_idle"); nd += int'(done);
    end
    chk("ab_done", nd, 0);

    // Async clear dominates preset; release shows preset at once.
    #1 aclr = 1; aset = 1; #1;
    mq = 0; rem = 0; mdone = 0;
    compare("aclr_aset");
    aclr = 0; #1;
    mq = 255;
    compare("aset_only");
    aset = 0;
    @(posedge clock); #1;

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      enable  = ($urandom % 8) != 0;
      sclr    = ($urandom % 25) == 0;
      sset    = ($urandom % 30) == 0;
      load    = ($urandom % 12) == 0;
      data    = 8'($urandom);
      shift   = ($urandom % 3) == 0;
      start   = ($urandom % 6) == 0;
      dir     = 1'($urandom);
      rotate  = 1'($urandom);
      shiftin = 1'($urandom);
      if (($urandom % 40) == 0) begin
        if ($urandom % 2) begin
          aclr = 1; #1; mq = 0;
        end else begin
          aset = 1; #1; mq = 255;
        end
        rem = 0; mdone = 0;
        compare("rnd_async");
        aclr = 0; aset = 0; #1;
      end
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
